// File: rtl/pu_argmax_if.sv
// Handshake bundle for the argmax classification stage:
// frame start/scores in, winning class/score out on valid/ready.
interface pu_argmax_if #(
   parameter int NUM_CLASS = 10,
   parameter int DW        = 32,
   parameter int IDX_W     = 4
);
   logic                      start_i;
   logic [NUM_CLASS*DW-1:0]   data_i;
   logic                      ready_i;
   logic                      busy_o;
   logic                      valid_o;
   logic [IDX_W-1:0]          class_o;
   logic [DW-1:0]             score_o;
   logic                      overrun_o;

   modport master (
      output start_i,
      output data_i,
      output ready_i,
      input  busy_o,
      input  valid_o,
      input  class_o,
      input  score_o,
      input  overrun_o
   );

   modport slave (
      input  start_i,
      input  data_i,
      input  ready_i,
      output busy_o,
      output valid_o,
      output class_o,
      output score_o,
      output overrun_o
   );
endinterface

// File: rtl/pu_argmax.sv
// Argmax over the final-layer class scores: latch a frame, scan one
// score per cycle, hold the winner until the downstream accepts it.
module pu_argmax #(
   parameter int NUM_CLASS = 10,
   parameter int DW        = 32,
   parameter int IDX_W     = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   pu_argmax_if.slave  io
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic signed [DW-1:0] bank [NUM_CLASS];
   logic signed [DW-1:0] best;
   logic [IDX_W-1:0]     best_idx;
   logic [IDX_W-1:0]     counter;

   logic [IDX_W-1:0]     class_q;
   logic [DW-1:0]        score_q;
   logic                 overrun_q;

   logic                 capture;
   logic                 last;
   logic                 gt;
   logic signed [DW-1:0] cand;
   logic signed [DW-1:0] win_score;
   logic [IDX_W-1:0]     win_idx;

   // A new frame is accepted when idle or when the held result
   // is being consumed on this very edge.
   assign capture = io.start_i &&
                    ((state == IDLE) ||
                     ((state == DONE) && io.ready_i));

   assign last = (counter == IDX_W'(NUM_CLASS - 1));

   // Strict compare so ties keep the lower index.
   assign cand      = bank[counter];
   assign gt        = (cand > best);
   assign win_score = gt ? cand : best;
   assign win_idx   = gt ? counter : best_idx;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (capture) state_nx = SCAN;
         end
         SCAN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            if (capture) begin
               state_nx = SCAN;
            end else if (io.ready_i) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      io.busy_o    = (state != IDLE);
      io.valid_o   = (state == DONE);
      io.class_o   = class_q;
      io.score_o   = score_q;
      io.overrun_o = overrun_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_CLASS; k++) begin
            bank[k] <= '0;
         end
         best      <= '0;
         best_idx  <= '0;
         counter   <= '0;
         class_q   <= '0;
         score_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (io.start_i && !capture) begin
            overrun_q <= 1'b1;
         end
         if (capture) begin
            for (int k = 0; k < NUM_CLASS; k++) begin
               bank[k] <= io.data_i[k*DW +: DW];
            end
            best     <= io.data_i[0 +: DW];
            best_idx <= '0;
            counter  <= IDX_W'(1);
         end else if (state == SCAN) begin
            best     <= win_score;
            best_idx <= win_idx;
            counter  <= counter + IDX_W'(1);
            // Result registers only move on entry to DONE.
            if (last) begin
               class_q <= win_idx;
               score_q <= win_score;
            end
         end
      end
   end

endmodule

// File: tb/tb_pu_argmax.sv
// Directed bench for pu_argmax: expected results queued at issue,
// popped and compared by a monitor on each output handshake.
module tb_pu_argmax;

   localparam int NC = 10;
   localparam int DW = 32;
   localparam int IW = 4;

   logic clk;
   logic rst;

   pu_argmax_if #(.NUM_CLASS(NC), .DW(DW), .IDX_W(IW)) bus ();

   pu_argmax #(.NUM_CLASS(NC), .DW(DW), .IDX_W(IW)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .io    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [35:0] sb [$];

   typedef logic signed [31:0] frame_t [NC];

   task automatic chk(input string nm, input logic [35:0] act,
                      input logic [35:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [NC*DW-1:0] pack(input frame_t f);
      logic [NC*DW-1:0] v;
      v = '0;
      for (int k = 0; k < NC; k++) begin
         v[k*DW +: DW] = f[k];
      end
      return v;
   endfunction

   // Monitor: every accepted result must match the oldest expectation.
   always @(negedge clk) begin
      logic [35:0] e;
      if (!rst && bus.valid_o && bus.ready_i) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", {bus.class_o, bus.score_o}, 36'h0);
            if ({bus.class_o, bus.score_o} == 36'h0) begin
               n_bad++;
               $display("FAIL unexpected_result: got a result, expected none");
            end
         end else begin
            e = sb.pop_front();
            chk("class", 36'(bus.class_o), 36'(e[35:32]));
            chk("score", 36'(bus.score_o), 36'(e[31:0]));
         end
      end
   end

   task automatic send(input frame_t f);
      @(posedge clk);
      #1;
      bus.start_i = 1'b1;
      bus.data_i  = pack(f);
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.data_i  = {NC{32'hA5A5_5A5A}};
   endtask

   task automatic wait_valid(input int n0, output int n,
                             output bit busy_ok, output bit hold_ok);
      logic [IW-1:0] c0;
      logic [DW-1:0] s0;
      c0 = bus.class_o;
      s0 = bus.score_o;
      n = n0;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      while (n < 40) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.valid_o) break;
         if (!bus.busy_o) busy_ok = 1'b0;
         if (bus.class_o !== c0 || bus.score_o !== s0) hold_ok = 1'b0;
      end
   endtask

   task automatic release_one();
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ready_i = 1'b0;
      chk("valid_after_hs", 36'(bus.valid_o), 36'h0);
      chk("busy_after_hs", 36'(bus.busy_o), 36'h0);
   endtask

   task automatic check_idle_after_hs();
      @(posedge clk);
      #1;
      chk("valid_after_hs", 36'(bus.valid_o), 36'h0);
      chk("busy_after_hs", 36'(bus.busy_o), 36'h0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, 36'(bus.busy_o), 36'h0);
      chk({tag, "_valid"}, 36'(bus.valid_o), 36'h0);
      chk({tag, "_class"}, 36'(bus.class_o), 36'h0);
      chk({tag, "_score"}, 36'(bus.score_o), 36'h0);
      chk({tag, "_overrun"}, 36'(bus.overrun_o), 36'h0);
   endtask

   initial begin
      frame_t f;
      frame_t g;
      int n;
      bit bok;
      bit hok;

      rst = 1'b1;
      bus.start_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.data_i  = '0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Distinct maximum at the last class
      bus.ready_i = 1'b1;
      f = '{5, -3, 12, 7, 0, 1, 2, 3, 4, 100000};
      sb.push_back({4'd9, 32'd100000});
      send(f);
      wait_valid(0, n, bok, hok);
      chk("lat_distinct", 36'(n), 36'd9);
      chk("busy_in_scan", 36'(bok), 36'h1);
      chk("overrun_clear", 36'(bus.overrun_o), 36'h0);
      check_idle_after_hs();

      // Tie between negatives keeps lower index
      f = '{-7, -7, -7, -1, -7, -7, -1, -7, -7, -7};
      sb.push_back({4'd3, 32'hFFFF_FFFF});
      send(f);
      wait_valid(0, n, bok, hok);
      chk("lat_tie", 36'(n), 36'd9);
      check_idle_after_hs();

      // All scores at the most negative value
      for (int k = 0; k < NC; k++) f[k] = 32'h8000_0000;
      sb.push_back({4'd0, 32'h8000_0000});
      send(f);
      wait_valid(0, n, bok, hok);
      chk("lat_minint", 36'(n), 36'd9);
      check_idle_after_hs();

      // Backpressure: result held for 20 cycles
      bus.ready_i = 1'b0;
      f = '{10, 20, 30, 40, -50, 60, -70, 5, 59, 0};
      sb.push_back({4'd5, 32'd60});
      send(f);
      wait_valid(0, n, bok, hok);
      chk("lat_bp", 36'(n), 36'd9);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", 36'(bus.valid_o), 36'h1);
         chk("bp_class", 36'(bus.class_o), 36'd5);
         chk("bp_score", 36'(bus.score_o), 36'd60);
      end
      release_one();

      // Back-to-back: new frame captured on the handshake edge
      f = '{0, 1, 20, 3, -4, 5, 6, 7, 8, 9};
      sb.push_back({4'd2, 32'd20});
      send(f);
      wait_valid(0, n, bok, hok);
      chk("lat_b2b_first", 36'(n), 36'd9);
      g = '{1, 50, -2, 3, 4, 5, 6, 7, 8, 9};
      sb.push_back({4'd1, 32'd50});
      bus.start_i = 1'b1;
      bus.data_i  = pack(g);
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.data_i  = {NC{32'h1234_5678}};
      chk("b2b_busy", 36'(bus.busy_o), 36'h1);
      chk("b2b_valid_low", 36'(bus.valid_o), 36'h0);
      chk("b2b_held_class", 36'(bus.class_o), 36'd2);
      wait_valid(0, n, bok, hok);
      chk("lat_b2b_second", 36'(n), 36'd9);
      chk("b2b_busy_kept", 36'(bok), 36'h1);
      chk("b2b_result_held", 36'(hok), 36'h1);
      release_one();

      // Overrun: start pulse 4 cycles into the scan is dropped
      bus.ready_i = 1'b1;
      f = '{-100, -200, -300, -50, -400, -60, -70, -80, -90, -55};
      sb.push_back({4'd3, 32'hFFFF_FFCE});
      send(f);
      repeat (3) @(posedge clk);
      #1;
      bus.start_i = 1'b1;
      bus.data_i  = {NC{32'd999}};
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      chk("overrun_set", 36'(bus.overrun_o), 36'h1);
      wait_valid(4, n, bok, hok);
      chk("lat_overrun", 36'(n), 36'd9);
      check_idle_after_hs();
      repeat (5) @(posedge clk);
      #1;
      chk("overrun_sticky", 36'(bus.overrun_o), 36'h1);

      // Asynchronous reset in the middle of a scan
      f = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
      send(f);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_zero("midrst");
      @(posedge clk);
      #2;
      rst = 1'b0;
      f = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
      sb.push_back({4'd5, 32'd9});
      send(f);
      wait_valid(0, n, bok, hok);
      chk("lat_after_rst", 36'(n), 36'd9);
      check_idle_after_hs();

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 36'(sb.size()), 36'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
